// File: rtl/led_blink_ctrl.sv
// LED blink controller: free-running prescaler, debounced mode button and a
// three-mode FSM (off / fixed rate from switches / automatic rate sweep).
module led_blink_ctrl #(
    parameter int N            = 27,
    parameter int DEB_BITS     = 20,
    parameter int SWEEP_BLINKS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn,
    input  logic [1:0] switch,
    output logic       led,
    output logic [1:0] rate_sel,
    output logic [1:0] mode
);
    localparam logic [1:0] MODE_OFF   = 2'b00;
    localparam logic [1:0] MODE_FIXED = 2'b01;
    localparam logic [1:0] MODE_SWEEP = 2'b10;
    localparam logic [1:0] MODE_BAD   = 2'b11;

    localparam int              BC_W       = (SWEEP_BLINKS > 1) ? $clog2(SWEEP_BLINKS) : 1;
    localparam logic [BC_W-1:0] BLINK_LAST = BC_W'(SWEEP_BLINKS - 1);

    logic [N-1:0]        prescaler;
    logic                sync1;
    logic                sync2;
    logic                stable;
    logic                stable_d;
    logic [DEB_BITS-1:0] deb_cnt;
    logic [BC_W-1:0]     blink_cnt;
    logic                prev_tap;

    logic            tap;
    logic            fall;
    logic            btn_pulse;
    logic [1:0]      mode_next;
    logic [1:0]      rate_next;
    logic [BC_W-1:0] blink_next;

    // Rate r selects prescaler bit N-1-r; r=0 is the slowest blink.
    function automatic logic tap_at(input logic [N-1:0] p, input logic [1:0] r);
        case (r)
            2'd0:    return p[N-1];
            2'd1:    return p[N-2];
            2'd2:    return p[N-3];
            default: return p[N-4];
        endcase
    endfunction

    assign tap       = tap_at(prescaler, rate_sel);
    assign fall      = prev_tap & ~tap;
    assign btn_pulse = stable & ~stable_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
            deb_cnt  <= '0;
        end else begin
            sync1    <= btn;
            sync2    <= sync1;
            stable_d <= stable;
            if (sync2 != stable) begin
                if (&deb_cnt) begin
                    stable  <= sync2;
                    deb_cnt <= '0;
                end else begin
                    deb_cnt <= deb_cnt + DEB_BITS'(1);
                end
            end else begin
                deb_cnt <= '0;
            end
        end
    end

    always_comb begin
        mode_next = mode;
        if (mode == MODE_BAD) begin
            mode_next = MODE_OFF;
        end else if (btn_pulse) begin
            case (mode)
                MODE_OFF:   mode_next = MODE_FIXED;
                MODE_FIXED: mode_next = MODE_SWEEP;
                default:    mode_next = MODE_OFF;
            endcase
        end
    end

    // Rate decisions follow the mode being entered, so a button pulse
    // overrides a sweep advance landing in the same cycle.
    always_comb begin
        rate_next  = rate_sel;
        blink_next = blink_cnt;
        case (mode_next)
            MODE_FIXED: rate_next = switch;
            MODE_SWEEP: begin
                if (mode != MODE_SWEEP) begin
                    rate_next  = 2'd0;
                    blink_next = '0;
                end else if (fall) begin
                    if (blink_cnt == BLINK_LAST) begin
                        rate_next  = rate_sel + 2'd1;
                        blink_next = '0;
                    end else begin
                        blink_next = blink_cnt + BC_W'(1);
                    end
                end
            end
            default:    rate_next = 2'd0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler <= '0;
            mode      <= MODE_OFF;
            rate_sel  <= 2'd0;
            blink_cnt <= '0;
            prev_tap  <= 1'b0;
            led       <= 1'b0;
        end else begin
            prescaler <= prescaler + N'(1);
            mode      <= mode_next;
            rate_sel  <= rate_next;
            blink_cnt <= blink_next;
            led       <= (mode_next == MODE_OFF) ? 1'b0 : tap;
            // Resample the edge detector on the new tap so a rate switch never fakes an edge.
            prev_tap  <= (rate_next != rate_sel) ? tap_at(prescaler, rate_next) : tap;
        end
    end

endmodule

// File: tb/tb_led_blink_ctrl.sv
// Bench for led_blink_ctrl: a cycle model feeds a scoreboard queue checked
// every cycle, plus directed latency, period, sweep and corner-case checks.
module tb_led_blink_ctrl;
    localparam int N            = 8;
    localparam int DEB_BITS     = 3;
    localparam int SWEEP_BLINKS = 2;

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic       btn    = 1'b0;
    logic [1:0] switch = 2'd0;
    logic       led;
    logic [1:0] rate_sel;
    logic [1:0] mode;

    led_blink_ctrl #(
        .N(N),
        .DEB_BITS(DEB_BITS),
        .SWEEP_BLINKS(SWEEP_BLINKS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn(btn),
        .switch(switch),
        .led(led),
        .rate_sel(rate_sel),
        .mode(mode)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       led;
        logic [1:0] rate;
        logic [1:0] mode;
    } exp_t;

    exp_t sb[$];
    int   n_cmp    = 0;
    int   n_bad    = 0;
    bit   model_on = 1'b1;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: behaviour of the block written out cycle by cycle.
    int m_psc = 0, m_s1 = 0, m_s2 = 0, m_stab = 0, m_stab_d = 0, m_dcnt = 0;
    int m_mode = 0, m_rate = 0, m_bcnt = 0, m_ptap = 0, m_led = 0;

    always @(posedge clk) begin
        int   tap, pulse, nmode, nrate, nbcnt;
        exp_t e;
        if (model_on) begin
            if (rst) begin
                m_psc = 0; m_s1 = 0; m_s2 = 0; m_stab = 0; m_stab_d = 0; m_dcnt = 0;
                m_mode = 0; m_rate = 0; m_bcnt = 0; m_ptap = 0; m_led = 0;
            end else begin
                tap   = (m_psc >> (N - 1 - m_rate)) & 1;
                pulse = (m_stab == 1 && m_stab_d == 0) ? 1 : 0;
                nmode = m_mode;
                if (m_mode == 3) nmode = 0;
                else if (pulse == 1) nmode = (m_mode + 1) % 3;
                nrate = m_rate;
                nbcnt = m_bcnt;
                if (nmode == 0) nrate = 0;
                else if (nmode == 1) nrate = int'(switch);
                else if (m_mode != 2) begin
                    nrate = 0;
                    nbcnt = 0;
                end else if (m_ptap == 1 && tap == 0) begin
                    nbcnt = m_bcnt + 1;
                    if (nbcnt == SWEEP_BLINKS) begin
                        nbcnt = 0;
                        nrate = (m_rate + 1) % 4;
                    end
                end
                m_led  = (nmode == 0) ? 0 : tap;
                m_ptap = (nrate != m_rate) ? ((m_psc >> (N - 1 - nrate)) & 1) : tap;
                m_mode = nmode;
                m_rate = nrate;
                m_bcnt = nbcnt;
                m_psc  = (m_psc + 1) % (1 << N);
                m_stab_d = m_stab;
                if (m_s2 != m_stab) begin
                    if (m_dcnt == (1 << DEB_BITS) - 1) begin
                        m_stab = m_s2;
                        m_dcnt = 0;
                    end else begin
                        m_dcnt++;
                    end
                end else begin
                    m_dcnt = 0;
                end
                m_s2 = m_s1;
                m_s1 = int'(btn);
            end
            e.led  = m_led[0];
            e.rate = m_rate[1:0];
            e.mode = m_mode[1:0];
            sb.push_back(e);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (model_on && sb.size() > 0) begin
            e = sb.pop_front();
            check_val("sb_led", int'(led), int'(e.led));
            check_val("sb_rate", int'(rate_sel), int'(e.rate));
            check_val("sb_mode", int'(mode), int'(e.mode));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic press(input int exp_mode);
        int old_mode, t;
        old_mode = int'(mode);
        btn = 1'b1;
        t = 0;
        while (int'(mode) == old_mode && t < 40) begin
            tick();
            t++;
        end
        check_val("press_latency", t, (1 << DEB_BITS) + 3);
        check_val("press_mode", int'(mode), exp_mode);
        while (t < 20) begin
            tick();
            t++;
        end
        btn = 1'b0;
        repeat (16) tick();
    endtask

    task automatic measure(input int r);
        int  t, hi, lo;
        logic prev;
        bit  rising;
        prev   = led;
        rising = 1'b0;
        t      = 0;
        while (!rising && t < 1000) begin
            tick();
            t++;
            rising = (prev == 1'b0 && led == 1'b1);
            prev   = led;
        end
        hi = 0;
        while (rising && led == 1'b1 && hi < 1000) begin
            tick();
            hi++;
        end
        lo = 0;
        while (rising && led == 1'b0 && lo < 1000) begin
            tick();
            lo++;
        end
        check_val($sformatf("fixed_high_r%0d", r), hi, (1 << (N - r)) / 2);
        check_val($sformatf("fixed_period_r%0d", r), hi + lo, 1 << (N - r));
    endtask

    task automatic wait_rate(input int r, input int limit);
        int t;
        t = 0;
        while (int'(rate_sel) != r && t < limit) begin
            tick();
            t++;
        end
        check_val("wait_rate", int'(rate_sel), r);
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        sb.delete();
        model_on = 1'b1;
        #1;
        check_val("rst_now_led", int'(led), 0);
        check_val("rst_now_rate", int'(rate_sel), 0);
        check_val("rst_now_mode", int'(mode), 0);
        repeat (cycles) begin
            tick();
            check_val("rst_hold_led", int'(led), 0);
            check_val("rst_hold_mode", int'(mode), 0);
        end
        rst = 1'b0;
    endtask

    initial begin
        repeat (3) tick();
        check_val("init_led", int'(led), 0);
        check_val("init_rate", int'(rate_sel), 0);
        check_val("init_mode", int'(mode), 0);
        rst = 1'b0;
        repeat (5) tick();

        // Short glitch must not register as a press.
        btn = 1'b1;
        repeat (5) tick();
        btn = 1'b0;
        repeat (20) tick();
        check_val("glitch_mode", int'(mode), 0);

        press(1);
        for (int r = 0; r < 4; r++) begin
            switch = 2'(r);
            repeat (4) tick();
            measure(r);
        end
        switch = 2'd0;
        repeat (3) tick();
        check_val("sw0_rate", int'(rate_sel), 0);
        switch = 2'd3;
        tick();
        check_val("sw3_rate", int'(rate_sel), 3);

        press(2);
        check_val("sweep_entry_rate", int'(rate_sel), 0);
        wait_rate(1, 700);
        for (int k = 0; k < 3; k++) begin
            int cur, t;
            cur = int'(rate_sel);
            t   = 0;
            while (int'(rate_sel) == cur && t < 600) begin
                switch = 2'($urandom_range(0, 3));
                tick();
                t++;
            end
            check_val("sweep_dwell", t, SWEEP_BLINKS * (1 << (N - 1 - k)));
            check_val("sweep_next", int'(rate_sel), (cur + 1) % 4);
        end

        // Land the button pulse on the cycle of the next rate advance.
        switch = 2'd0;
        wait_rate(1, 700);
        repeat (SWEEP_BLINKS * (1 << (N - 1)) - ((1 << DEB_BITS) + 3)) tick();
        btn = 1'b1;
        repeat ((1 << DEB_BITS) + 3) tick();
        check_val("collide_mode", int'(mode), 0);
        check_val("collide_rate", int'(rate_sel), 0);
        check_val("collide_led", int'(led), 0);
        repeat (9) tick();
        btn = 1'b0;
        repeat (16) tick();

        press(1);
        press(2);
        press(0);
        press(1);

        switch = 2'd3;
        repeat (40) tick();
        do_reset(3);
        repeat (40) tick();

        press(1);
        repeat (20) tick();
        model_on = 1'b0;
        force dut.mode = 2'b11;
        tick();
        check_val("illegal_led", int'(led), 0);
        check_val("illegal_rate", int'(rate_sel), 0);
        release dut.mode;
        tick();
        check_val("illegal_mode", int'(mode), 0);
        check_val("illegal_led2", int'(led), 0);

        do_reset(2);
        repeat (30) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/led_blink_ctrl.md
# led_blink_ctrl

Mode and rate controller for the board's LED blink path. It owns a synchronous N-bit prescaler and debounces a push button that cycles the block through three modes: off, fixed rate taken from the switches, and an automatic sweep through all four rates. It produces the LED drive plus the active rate and mode for status display, and sits between the board I/O (clk, rst, btn, switch) and the LED pin.

## Interface
- N, 27: prescaler width; rate r uses tap bit N-1-r (r=0 gives the slowest blink, clk/2^N).
- DEB_BITS, 20: debounce counter width; the input must hold for 2^DEB_BITS cycles to be accepted.
- SWEEP_BLINKS, 4: complete LED periods spent on each rate in sweep mode (≥1).

- clk  in  1  system clock, single clock domain.
- rst  in  1  asynchronous, active-high reset; clears all state.
- btn  in  1  raw mode button, asynchronous to clk, bouncy, active-high.
- switch  in  2  rate select used in FIXED mode.
- led  out  1  registered LED drive.
- rate_sel  out  2  rate currently applied to the tap mux.
- mode  out  2  00 OFF, 01 FIXED, 10 SWEEP.

## Operation
- Prescaler: N-bit up counter, +1 every clk, wraps 2^N-1→0, never stalled. The tap value is prescaler[N-1-rate_sel].
- Button path:
  - 2-FF synchronizer, then debouncer with a stable register (reset value 0) and a DEB_BITS counter.
  - When synced ≠ stable, the counter increments. When they are equal, the counter clears to 0.
  - When synced ≠ stable and the counter is all-ones, stable ← synced and the counter clears.
  - btn_pulse is an internal 1-cycle strobe on a 0→1 transition of stable.
- Mode FSM, advanced by btn_pulse only:
  - OFF→FIXED→SWEEP→OFF.
  - Code 11 is illegal and goes to OFF on the next cycle.
- OFF: led ← 0, rate_sel ← 0.
- FIXED: rate_sel ← switch every cycle; led ← tap.
- SWEEP:
  - Entry sets rate_sel ← 0 and clears blink_cnt.
  - led ← tap.
  - A falling edge of tap (prev_tap=1, tap=0) increments blink_cnt.
  - When blink_cnt reaches SWEEP_BLINKS-1 and another falling edge occurs: rate_sel ← rate_sel+1 mod 4 (3→0 wraps) and blink_cnt ← 0.
- Rate-change rule, all modes: in any cycle where rate_sel changes, prev_tap is reloaded from the new tap and no edge is counted that cycle.
- A btn_pulse in the same cycle as a sweep rate advance: the mode transition wins and the advance is discarded.
- Switch changes in SWEEP and OFF are ignored.
- Reset values: led=0, rate_sel=00, mode=00, prescaler=0, stable=0, debounce counter=0, synchronizer FFs=0, blink_cnt=0, prev_tap=0.
- Asserting rst mid-operation clears everything immediately. After release the block is in OFF and the button must be re-pressed.

## Timing
- led is registered: it reflects the prescaler/rate state of the previous cycle (1-cycle latency).
- FIXED: a switch change appears on rate_sel 1 cycle later and on led 2 cycles later.
- Button press to mode update:
  - 2 synchronizer cycles + 2^DEB_BITS debounce cycles + 1 FSM cycle.
  - mode changes exactly 2^DEB_BITS+3 cycles after btn rises, when btn is clean and meets setup.
- Button release is debounced the same way but produces no pulse.
- Bounce rule: any glitch shorter than 2^DEB_BITS cycles produces no pulse.
- Blink period at rate r: 2^(N-r) cycles, 50 % duty.
- mode and rate_sel are registered outputs and are glitch-free.

## Test plan
Use N=8, DEB_BITS=3, SWEEP_BLINKS=2 throughout.

- Reset: assert rst for 3 cycles mid-count → led=0, rate_sel=0, mode=0 within the same cycle, held until released; the prescaler restarts from 0.
- Debounce:
  - Clean btn pulse held 20 cycles → mode 00→01 exactly 11 cycles after the rising edge.
  - 5-cycle glitch → mode unchanged.
  - 4 clean presses → mode sequence 01, 10, 00, 01.
- FIXED rates: switch=0..3 → led period 256/128/64/32 cycles, high half-period 128/64/32/16. A switch change 0→3 shows rate_sel=3 after 1 cycle.
- SWEEP:
  - Enter SWEEP → rate_sel=0.
  - After the 2nd falling edge of bit 7 → rate_sel=1, then rate 2 after 2 further falls of bit 6.
  - 3→0 wrap observed.
  - Switch toggling has no effect.
- Collision: btn_pulse coincident with a sweep advance cycle → mode=OFF, rate_sel=0, led=0 next cycle. No advance is recorded.
- Illegal state: force mode=11 → OFF after 1 cycle, led=0.
